// File: rtl/mem_port_arbiter.sv
// Round-robin sharing of one memory port between the core (0) and the loader (1).
// REQ sampled at edge k -> MEM_EN k+1..k+ACCESS_CYCLES, DONE pulse next cycle; no backpressure, losers wait in IDLE.
module mem_port_arbiter #(
  parameter int ADDR_W        = 8,
  parameter int DATA_W        = 8,
  parameter int ACCESS_CYCLES = 2
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              REQ0,
  input  logic              RORW0,
  input  logic [ADDR_W-1:0] ADD0,
  input  logic [DATA_W-1:0] WDATA0,
  input  logic              REQ1,
  input  logic              RORW1,
  input  logic [ADDR_W-1:0] ADD1,
  input  logic [DATA_W-1:0] WDATA1,
  output logic              GNT0,
  output logic              GNT1,
  output logic              DONE0,
  output logic              DONE1,
  output logic [DATA_W-1:0] RDATA,
  input  logic [DATA_W-1:0] D_IN,
  output logic [ADDR_W-1:0] ADD,
  output logic [DATA_W-1:0] D_OUT,
  output logic              RORW,
  output logic              MEM_EN,
  output logic [1:0]        STATE
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_DONE   = 2'b10
  } state_e;

  localparam logic [3:0] LAST_CNT = 4'(ACCESS_CYCLES);

  state_e            state_q, state_d;
  logic              gnt0_q, gnt0_d;
  logic              gnt1_q, gnt1_d;
  logic              done0_q, done0_d;
  logic              done1_q, done1_d;
  logic              mem_en_q, mem_en_d;
  logic              rorw_q, rorw_d;
  logic              last_q, last_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] add_q, add_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic              win_vld;
  logic              win_sel;
  logic              win_rorw;
  logic [ADDR_W-1:0] win_add;
  logic [DATA_W-1:0] win_wdata;

  // On a tie the requester that was not served last wins.
  always_comb begin
    win_vld   = REQ0 | REQ1;
    win_sel   = (REQ0 && REQ1) ? ~last_q : REQ1;
    win_rorw  = win_sel ? RORW1  : RORW0;
    win_add   = win_sel ? ADD1   : ADD0;
    win_wdata = win_sel ? WDATA1 : WDATA0;
  end

  always_comb begin
    state_d  = state_q;
    gnt0_d   = gnt0_q;
    gnt1_d   = gnt1_q;
    done0_d  = done0_q;
    done1_d  = done1_q;
    mem_en_d = mem_en_q;
    rorw_d   = rorw_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    add_d    = add_q;
    dout_d   = dout_q;
    rdata_d  = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (win_vld) begin
          state_d  = ST_ACCESS;
          gnt0_d   = ~win_sel;
          gnt1_d   = win_sel;
          mem_en_d = 1'b1;
          last_d   = win_sel;
          cnt_d    = 4'd1;
          add_d    = win_add;
          rorw_d   = win_rorw;
          dout_d   = win_rorw ? '0 : win_wdata;
        end
      end
      ST_ACCESS: begin
        // Requester inputs are deliberately ignored here: a dropped REQ does not abort.
        if (cnt_q == LAST_CNT) begin
          if (rorw_q) begin
            rdata_d = D_IN;
          end
          mem_en_d = 1'b0;
          dout_d   = '0;
          done0_d  = gnt0_q;
          done1_d  = gnt1_q;
          cnt_d    = 4'd0;
          state_d  = ST_DONE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_DONE: begin
        done0_d = 1'b0;
        done1_d = 1'b0;
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        add_d   = '0;
        rorw_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= ST_IDLE;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      mem_en_q <= 1'b0;
      rorw_q   <= 1'b1;
      last_q   <= 1'b1;
      cnt_q    <= 4'd0;
      add_q    <= '0;
      dout_q   <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      gnt0_q   <= gnt0_d;
      gnt1_q   <= gnt1_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
      mem_en_q <= mem_en_d;
      rorw_q   <= rorw_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      add_q    <= add_d;
      dout_q   <= dout_d;
      rdata_q  <= rdata_d;
    end
  end

  assign GNT0   = gnt0_q;
  assign GNT1   = gnt1_q;
  assign DONE0  = done0_q;
  assign DONE1  = done1_q;
  assign RDATA  = rdata_q;
  assign ADD    = add_q;
  assign D_OUT  = dout_q;
  assign RORW   = rorw_q;
  assign MEM_EN = mem_en_q;
  assign STATE  = state_q;

  a_gnt_excl: assert property (@(posedge CLK) disable iff (RESET) !(GNT0 && GNT1));
  a_en_in_access: assert property (@(posedge CLK) disable iff (RESET) MEM_EN |-> (STATE == 2'b01));
  a_done0_pulse: assert property (@(posedge CLK) disable iff (RESET) DONE0 |=> !DONE0);
  a_done1_pulse: assert property (@(posedge CLK) disable iff (RESET) DONE1 |=> !DONE1);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter at ACCESS_CYCLES = 2, 1 and 15, driven one instance at a time
// against a transaction-level model of arbitration and access timing.
module tb_mem_port_arbiter;

  localparam int NI = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic       rst    [NI];
  logic       req0   [NI];
  logic       rorw0  [NI];
  logic [7:0] add0   [NI];
  logic [7:0] wdata0 [NI];
  logic       req1   [NI];
  logic       rorw1  [NI];
  logic [7:0] add1   [NI];
  logic [7:0] wdata1 [NI];
  logic [7:0] d_in   [NI];
  logic       gnt0   [NI];
  logic       gnt1   [NI];
  logic       done0  [NI];
  logic       done1  [NI];
  logic [7:0] rdata  [NI];
  logic [7:0] add    [NI];
  logic [7:0] d_out  [NI];
  logic       rorw   [NI];
  logic       mem_en [NI];
  logic [1:0] state  [NI];

  task automatic check_eq(input string tag, input int inst, input logic [31:0] got,
                          input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s u%0d t=%0t: got 0x%0h expected 0x%0h", tag, inst, $time, got, exp);
    end
  endtask

  function automatic int ac_of(input int i);
    return (i == 0) ? 2 : ((i == 1) ? 1 : 15);
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_inst
    localparam int AC = (g == 0) ? 2 : ((g == 1) ? 1 : 15);

    mem_port_arbiter #(.ADDR_W(8), .DATA_W(8), .ACCESS_CYCLES(AC)) u_dut (
      .CLK(clk), .RESET(rst[g]),
      .REQ0(req0[g]), .RORW0(rorw0[g]), .ADD0(add0[g]), .WDATA0(wdata0[g]),
      .REQ1(req1[g]), .RORW1(rorw1[g]), .ADD1(add1[g]), .WDATA1(wdata1[g]),
      .GNT0(gnt0[g]), .GNT1(gnt1[g]), .DONE0(done0[g]), .DONE1(done1[g]),
      .RDATA(rdata[g]), .D_IN(d_in[g]), .ADD(add[g]), .D_OUT(d_out[g]),
      .RORW(rorw[g]), .MEM_EN(mem_en[g]), .STATE(state[g])
    );

    // Model: one transaction in flight, n = edges since its grant.
    logic       rst_w;
    logic       pick1;
    bit         busy;
    int         n;
    bit         who;
    bit         last;
    bit         t_rorw;
    logic [7:0] t_add, t_wd, exp_rdata;
    int         en_run;

    assign rst_w = rst[g];
    assign pick1 = (req0[g] && req1[g]) ? !last : req1[g];

    always @(posedge clk or posedge rst_w) begin
      if (rst_w) begin
        busy      <= 1'b0;
        n         <= 0;
        last      <= 1'b1;
        exp_rdata <= 8'h00;
      end else if (busy) begin
        if (n + 1 == AC && t_rorw) exp_rdata <= d_in[g];
        if (n + 1 == AC + 1) busy <= 1'b0;
        n <= n + 1;
      end else if (req0[g] || req1[g]) begin
        busy   <= 1'b1;
        n      <= 0;
        who    <= pick1;
        last   <= pick1;
        t_rorw <= pick1 ? rorw1[g] : rorw0[g];
        t_add  <= pick1 ? add1[g] : add0[g];
        t_wd   <= pick1 ? wdata1[g] : wdata0[g];
      end
    end

    logic       e_gnt0, e_gnt1, e_done0, e_done1, e_mem_en, e_rorw;
    logic [7:0] e_add, e_dout;
    logic [1:0] e_state;

    always_comb begin
      e_gnt0 = 1'b0; e_gnt1 = 1'b0; e_done0 = 1'b0; e_done1 = 1'b0;
      e_mem_en = 1'b0; e_rorw = 1'b1; e_add = 8'h00; e_dout = 8'h00; e_state = 2'b00;
      if (busy && !rst_w) begin
        e_gnt0 = !who;
        e_gnt1 = who;
        e_add  = t_add;
        e_rorw = t_rorw;
        if (n < AC) begin
          e_mem_en = 1'b1;
          e_state  = 2'b01;
          e_dout   = t_rorw ? 8'h00 : t_wd;
        end else begin
          e_state = 2'b10;
          e_done0 = !who;
          e_done1 = who;
        end
      end
    end

    always @(negedge clk) begin
      check_eq("gnt0", g, gnt0[g], e_gnt0);
      check_eq("gnt1", g, gnt1[g], e_gnt1);
      check_eq("done0", g, done0[g], e_done0);
      check_eq("done1", g, done1[g], e_done1);
      check_eq("mem_en", g, mem_en[g], e_mem_en);
      check_eq("add", g, add[g], e_add);
      check_eq("d_out", g, d_out[g], e_dout);
      check_eq("rorw", g, rorw[g], e_rorw);
      check_eq("state", g, state[g], e_state);
      check_eq("rdata", g, rdata[g], exp_rdata);
      if (rst_w) begin
        en_run <= 0;
      end else if (mem_en[g] === 1'b1) begin
        en_run <= en_run + 1;
      end else begin
        if (en_run != 0) check_eq("mem_en_len", g, en_run, AC);
        en_run <= 0;
      end
    end
  end

  task automatic step(input int i, input bit rnd);
    @(posedge clk);
    #2;
    if (rnd) d_in[i] = 8'($urandom);
  endtask

  task automatic wait_done(input int i, input int r, input bit rnd);
    bit ok = 1'b0;
    for (int c = 0; c < 60; c++) begin
      step(i, rnd);
      if ((r == 0) ? done0[i] : done1[i]) begin
        ok = 1'b1;
        break;
      end
    end
    check_eq("done_wait", i, ok, 1);
  endtask

  task automatic wait_any(input int i, output int who);
    bit ok = 1'b0;
    who = -1;
    for (int c = 0; c < 60; c++) begin
      step(i, 1'b1);
      if (done0[i] || done1[i]) begin
        ok  = 1'b1;
        who = done1[i] ? 1 : 0;
        break;
      end
    end
    check_eq("any_wait", i, ok, 1);
  endtask

  task automatic wait_gnt0(input int i);
    bit ok = 1'b0;
    for (int c = 0; c < 60; c++) begin
      step(i, 1'b1);
      if (gnt0[i]) begin
        ok = 1'b1;
        break;
      end
    end
    check_eq("gnt_wait", i, ok, 1);
  endtask

  task automatic new_req(input int i, input int r);
    if (r == 0) begin
      req0[i] = 1'b1; rorw0[i] = 1'($urandom);
      add0[i] = 8'($urandom); wdata0[i] = 8'($urandom);
    end else begin
      req1[i] = 1'b1; rorw1[i] = 1'($urandom);
      add1[i] = 8'($urandom); wdata1[i] = 8'($urandom);
    end
  endtask

  task automatic run_inst(input int i);
    int who;
    rst[i] = 1'b1;
    repeat (3) step(i, 1'b0);
    rst[i] = 1'b0;
    step(i, 1'b0);

    // Directed read by requester 0.
    req0[i] = 1'b1; rorw0[i] = 1'b1; add0[i] = 8'h01; wdata0[i] = 8'h33; d_in[i] = 8'hAA;
    wait_done(i, 0, 1'b0);
    req0[i] = 1'b0;
    step(i, 1'b1);
    check_eq("rd_data", i, rdata[i], 8'hAA);

    // Directed write by requester 1: RDATA must survive it.
    req1[i] = 1'b1; rorw1[i] = 1'b0; add1[i] = 8'h04; wdata1[i] = 8'hFE;
    wait_done(i, 1, 1'b1);
    req1[i] = 1'b0;
    step(i, 1'b1);
    check_eq("wr_keeps_rdata", i, rdata[i], 8'hAA);

    // Both held: requester 1 was served last, so order is 0,1,0,1.
    new_req(i, 0);
    new_req(i, 1);
    for (int k = 0; k < 4; k++) begin
      wait_any(i, who);
      check_eq("tie_order", i, who, k % 2);
      new_req(i, who);
    end
    req0[i] = 1'b0; req1[i] = 1'b0;
    repeat (3) step(i, 1'b1);

    // Request dropped during ACCESS still completes.
    new_req(i, 0);
    wait_gnt0(i);
    req0[i] = 1'b0;
    wait_done(i, 0, 1'b1);
    repeat (2) step(i, 1'b1);

    // Reset in the middle of an access.
    req0[i] = 1'b1; rorw0[i] = 1'b1; add0[i] = 8'h5A;
    wait_gnt0(i);
    rst[i] = 1'b1;
    #1;
    check_eq("rst_mem_en", i, mem_en[i], 0);
    check_eq("rst_gnt0", i, gnt0[i], 0);
    check_eq("rst_state", i, state[i], 0);
    check_eq("rst_rdata", i, rdata[i], 0);
    req0[i] = 1'b0;
    repeat (2) step(i, 1'b1);
    rst[i] = 1'b0;
    repeat (2) step(i, 1'b1);
    check_eq("rst_no_done", i, done0[i], 0);

    // Random traffic; each requester holds REQ and its fields until DONE.
    for (int c = 0; c < 300 + 20 * ac_of(i); c++) begin
      step(i, 1'b1);
      if (req0[i] && done0[i]) req0[i] = 1'b0;
      if (req1[i] && done1[i]) req1[i] = 1'b0;
      if (!req0[i] && $urandom_range(0, 2) == 0) new_req(i, 0);
      if (!req1[i] && $urandom_range(0, 2) == 0) new_req(i, 1);
    end
    req0[i] = 1'b0; req1[i] = 1'b0;
    repeat (40) step(i, 1'b1);
  endtask

  initial begin
    for (int i = 0; i < NI; i++) begin
      rst[i] = 1'b1;
      req0[i] = 1'b0; rorw0[i] = 1'b1; add0[i] = 8'h00; wdata0[i] = 8'h00;
      req1[i] = 1'b0; rorw1[i] = 1'b1; add1[i] = 8'h00; wdata1[i] = 8'h00;
      d_in[i] = 8'h00;
    end
    for (int i = 0; i < NI; i++) run_inst(i);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete, checks=%0d errors=%0d",
             n_checks, n_errors);
    $fatal(1, "timeout");
  end

endmodule
